// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator.
// Each mode set bundles porch/sync geometry, polarities and the pixel-enable divider.
package vga_timing_pkg;

    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic h_pol;
        logic v_pol;
        int   pix_div;
    } vga_mode_t;

    // 800x600@72 Hz from a 50 MHz clock with pix_en held high.
    localparam vga_mode_t MODE_800X600_72 = '{
        h_active: 32'd800, h_fp: 32'd56, h_sync: 32'd120, h_bp: 32'd64,
        v_active: 32'd600, v_fp: 32'd37, v_sync: 32'd6,   v_bp: 32'd23,
        h_pol: 1'b0, v_pol: 1'b0, pix_div: 32'd1
    };

    // 640x480@60 Hz: 25 MHz pixel rate, pix_en every second clk of 50 MHz.
    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 32'd640, h_fp: 32'd16, h_sync: 32'd96, h_bp: 32'd48,
        v_active: 32'd480, v_fp: 32'd10, v_sync: 32'd2,  v_bp: 32'd33,
        h_pol: 1'b0, v_pol: 1'b0, pix_div: 32'd2
    };

    // Counter width able to hold 0..total-1, never narrower than one bit.
    function automatic int cnt_width(input int total);
        if ($clog2(total) < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(total);
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with sync-window and active-area decode.
// wrap pulses on the advance that returns the counter to 0, so it can chain the next axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE = 32'sd800,
    parameter int   FP     = 32'sd56,
    parameter int   SYNC   = 32'sd120,
    parameter int   BP     = 32'sd64,
    parameter logic POL    = 1'b0,
    localparam int  TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int  W      = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    if (FP < 32'sd1 || SYNC < 32'sd1 || BP < 32'sd1 || ACTIVE < 32'sd0 || TOTAL < 32'sd2) begin : g_param_check
        $error("vga_axis_counter: porch/sync widths must be >= 1 and total >= 2");
    end

    logic [W-1:0] count_r;
    logic         terminal_s;
    logic         in_sync_s;

    assign count      = count_r;
    assign terminal_s = (count_r == W'(TOTAL - 32'sd1));
    assign wrap       = adv & terminal_s;

    // Position counter: advance on adv, return to 0 after the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (adv) begin
            if (terminal_s) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + 1'b1;
            end
        end
    end

    // Decode of the current position into sync level and active-area flag.
    always_comb begin
        in_sync_s = 1'b0;
        active    = 1'b0;
        if ((count_r >= W'(ACTIVE + FP)) && (count_r < W'(ACTIVE + FP + SYNC))) begin
            in_sync_s = 1'b1;
        end else begin
            in_sync_s = 1'b0;
        end
        if (count_r < W'(ACTIVE)) begin
            active = 1'b1;
        end else begin
            active = 1'b0;
        end
    end

    assign sync = in_sync_s ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised single-clock VGA raster timing generator; all outputs are registered
// one pix_en update behind the counters and describe the same pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = MODE_800X600_72.h_active,
    parameter int   H_FP       = MODE_800X600_72.h_fp,
    parameter int   H_SYNC     = MODE_800X600_72.h_sync,
    parameter int   H_BP       = MODE_800X600_72.h_bp,
    parameter int   V_ACTIVE   = MODE_800X600_72.v_active,
    parameter int   V_FP       = MODE_800X600_72.v_fp,
    parameter int   V_SYNC     = MODE_800X600_72.v_sync,
    parameter int   V_BP       = MODE_800X600_72.v_bp,
    parameter logic H_POL      = MODE_800X600_72.h_pol,
    parameter logic V_POL      = MODE_800X600_72.v_pol,
    parameter int   ADDR_SHIFT = 32'sd2,
    parameter int   ADDR_W_X   = 32'sd8,
    parameter int   ADDR_W_Y   = 32'sd8,
    localparam int  X_W        = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int  Y_W        = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_en,
    output logic                         h_sync_o,
    output logic                         v_sync_o,
    output logic                         in_disp_o,
    output logic [X_W-1:0]               x_o,
    output logic [Y_W-1:0]               y_o,
    output logic [ADDR_W_Y+ADDR_W_X-1:0] pixel_addr_o,
    output logic                         line_start_o,
    output logic                         frame_start_o
);

    logic [X_W-1:0]               h_cnt_s;
    logic [Y_W-1:0]               v_cnt_s;
    logic                         h_wrap_s;
    logic                         frame_end_unused_s;
    logic                         h_sync_s;
    logic                         v_sync_s;
    logic                         h_act_s;
    logic                         v_act_s;
    logic                         in_disp_s;
    logic                         line_start_s;
    logic                         frame_start_s;
    logic [ADDR_W_Y+ADDR_W_X-1:0] addr_s;

    logic                         h_sync_r;
    logic                         v_sync_r;
    logic                         in_disp_r;
    logic [X_W-1:0]               x_r;
    logic [Y_W-1:0]               y_r;
    logic [ADDR_W_Y+ADDR_W_X-1:0] addr_r;
    logic                         line_start_r;
    logic                         frame_start_r;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .adv    (pix_en),
        .count  (h_cnt_s),
        .wrap   (h_wrap_s),
        .sync   (h_sync_s),
        .active (h_act_s)
    );

    // The vertical axis steps only on the horizontal wrap, which already includes pix_en.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .adv    (h_wrap_s),
        .count  (v_cnt_s),
        .wrap   (frame_end_unused_s),
        .sync   (v_sync_s),
        .active (v_act_s)
    );

    // Pixel decode: display flag, blanked framebuffer address and start strobes.
    always_comb begin
        in_disp_s     = h_act_s & v_act_s;
        addr_s        = '0;
        line_start_s  = 1'b0;
        frame_start_s = 1'b0;
        if (in_disp_s) begin
            addr_s = {ADDR_W_Y'(v_cnt_s >> ADDR_SHIFT), ADDR_W_X'(h_cnt_s >> ADDR_SHIFT)};
        end else begin
            addr_s = '0;
        end
        if (pix_en && (h_cnt_s == '0)) begin
            line_start_s  = 1'b1;
            frame_start_s = (v_cnt_s == '0);
        end else begin
            line_start_s  = 1'b0;
            frame_start_s = 1'b0;
        end
    end

    // Output registers: levels load on pix_en and hold otherwise; strobes follow every clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_sync_r      <= ~H_POL;
            v_sync_r      <= ~V_POL;
            in_disp_r     <= 1'b0;
            x_r           <= '0;
            y_r           <= '0;
            addr_r        <= '0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
            if (pix_en) begin
                h_sync_r  <= h_sync_s;
                v_sync_r  <= v_sync_s;
                in_disp_r <= in_disp_s;
                x_r       <= h_cnt_s;
                y_r       <= v_cnt_s;
                addr_r    <= addr_s;
            end
        end
    end

    assign h_sync_o      = h_sync_r;
    assign v_sync_o      = v_sync_r;
    assign in_disp_o     = in_disp_r;
    assign x_o           = x_r;
    assign y_o           = y_r;
    assign pixel_addr_o  = addr_r;
    assign line_start_o  = line_start_r;
    assign frame_start_o = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default 800x600 timing, a tiny
// positive-polarity mode, and a short-line mode that reaches the full 666-line frame quickly.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: default 800x600@72
    logic        rst_a, pen_a;
    logic        a_hs, a_vs, a_disp, a_ls, a_fs;
    logic [10:0] a_x;
    logic [9:0]  a_y;
    logic [15:0] a_addr;

    // B: H 8/2/3/3, V 4/1/2/1, positive syncs
    logic        rst_b, pen_b;
    logic        b_hs, b_vs, b_disp, b_ls, b_fs;
    logic [3:0]  b_x;
    logic [2:0]  b_y;
    logic [15:0] b_addr;

    // C: H 8/2/3/3, V default 600/37/6/23, negative syncs
    logic        rst_c, pen_c;
    logic        c_hs, c_vs, c_disp, c_ls, c_fs;
    logic [3:0]  c_x;
    logic [9:0]  c_y;
    logic [15:0] c_addr;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(pen_a),
        .h_sync_o(a_hs), .v_sync_o(a_vs), .in_disp_o(a_disp),
        .x_o(a_x), .y_o(a_y), .pixel_addr_o(a_addr),
        .line_start_o(a_ls), .frame_start_o(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(pen_b),
        .h_sync_o(b_hs), .v_sync_o(b_vs), .in_disp_o(b_disp),
        .x_o(b_x), .y_o(b_y), .pixel_addr_o(b_addr),
        .line_start_o(b_ls), .frame_start_o(b_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3)
    ) dut_c (
        .clk(clk), .rst(rst_c), .pix_en(pen_c),
        .h_sync_o(c_hs), .v_sync_o(c_vs), .in_disp_o(c_disp),
        .x_o(c_x), .y_o(c_y), .pixel_addr_o(c_addr),
        .line_start_o(c_ls), .frame_start_o(c_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int lo_cnt, first_lo, last_lo, ls_cnt, fs_cnt, disp_cnt, disp_bad;
    logic        disp799, disp800;
    logic [15:0] addr799, addr800, addr_c;

    initial begin
        rst_a = 1'b1; pen_a = 1'b1;
        rst_b = 1'b1; pen_b = 1'b0;
        rst_c = 1'b1; pen_c = 1'b0;
        step(); step();

        // ---- A: reset state ----
        check("a_rst_x", a_x, 0);
        check("a_rst_y", a_y, 0);
        check("a_rst_hs", a_hs, 1);
        check("a_rst_vs", a_vs, 1);
        check("a_rst_disp", a_disp, 0);
        check("a_rst_addr", a_addr, 0);
        check("a_rst_ls", a_ls, 0);
        check("a_rst_fs", a_fs, 0);

        // ---- A: first update is pixel (0,0) with both strobes ----
        rst_a = 1'b0;
        step();
        check("a_first_x", a_x, 0);
        check("a_first_y", a_y, 0);
        check("a_first_disp", a_disp, 1);
        check("a_first_ls", a_ls, 1);
        check("a_first_fs", a_fs, 1);
        check("a_first_hs", a_hs, 1);
        step();
        check("a_k1_x", a_x, 1);
        check("a_k1_ls", a_ls, 0);
        check("a_k1_fs", a_fs, 0);

        // ---- A: rest of line 0 ----
        lo_cnt = 0; first_lo = -1; last_lo = -1; ls_cnt = 0;
        disp799 = 1'b0; disp800 = 1'b1; addr799 = 16'd0; addr800 = 16'hFFFF;
        for (int k = 1; k < 1040; k++) begin
            if (a_hs == 1'b0) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = int'(a_x);
                last_lo = int'(a_x);
            end
            if (a_ls) ls_cnt++;
            if (a_x == 11'd799) begin disp799 = a_disp; addr799 = a_addr; end
            if (a_x == 11'd800) begin disp800 = a_disp; addr800 = a_addr; end
            step();
        end
        check("a_hs_low_len", lo_cnt, 120);
        check("a_hs_first_x", first_lo, 856);
        check("a_hs_last_x", last_lo, 975);
        check("a_ls_inline", ls_cnt, 0);
        check("a_disp_x799", disp799, 1);
        check("a_addr_x799_y0", addr799, 16'h00C7);
        check("a_disp_x800", disp800, 0);
        check("a_addr_x800", addr800, 0);
        check("a_line2_x", a_x, 0);
        check("a_line2_y", a_y, 1);
        check("a_line2_ls", a_ls, 1);
        check("a_line2_fs", a_fs, 0);

        // ---- A: address at (799,4) and blanking at (800,4) ----
        repeat (3919) step();
        check("a_pos_x799", a_x, 799);
        check("a_pos_y4", a_y, 4);
        check("a_addr_x799_y4", a_addr, 16'h01C7);
        step();
        check("a_addr_x800_y4", a_addr, 0);
        check("a_disp_x800_y4", a_disp, 0);

        // ---- A: reset in the middle of an hsync pulse at (900,5) ----
        repeat (1140) step();
        check("a_mid_x", a_x, 900);
        check("a_mid_y", a_y, 5);
        check("a_mid_hs", a_hs, 0);
        rst_a = 1'b1;
        step();
        check("a_mrst_x", a_x, 0);
        check("a_mrst_y", a_y, 0);
        check("a_mrst_hs", a_hs, 1);
        check("a_mrst_disp", a_disp, 0);
        check("a_mrst_ls", a_ls, 0);

        // ---- A: pix_en toggling after reset ----
        rst_a = 1'b0; pen_a = 1'b0;
        step();
        check("a_hold_x", a_x, 0);
        check("a_hold_ls", a_ls, 0);
        check("a_hold_hs", a_hs, 1);
        pen_a = 1'b1;
        step();
        check("a_t1_x", a_x, 0);
        check("a_t1_y", a_y, 0);
        check("a_t1_ls", a_ls, 1);
        check("a_t1_fs", a_fs, 1);
        check("a_t1_disp", a_disp, 1);
        pen_a = 1'b0;
        step();
        check("a_t2_x", a_x, 0);
        check("a_t2_ls", a_ls, 0);
        check("a_t2_fs", a_fs, 0);
        check("a_t2_disp", a_disp, 1);
        pen_a = 1'b1;
        step();
        check("a_t3_x", a_x, 1);
        check("a_t3_ls", a_ls, 0);
        pen_a = 1'b0;
        step();
        check("a_t4_x", a_x, 1);
        pen_a = 1'b1;
        step();
        check("a_t5_x", a_x, 2);

        // ---- B: small positive-polarity mode ----
        pen_b = 1'b1;
        step();
        check("b_rst_hs", b_hs, 0);
        check("b_rst_vs", b_vs, 0);
        rst_b = 1'b0;
        step();
        lo_cnt = 0; first_lo = -1; last_lo = -1; ls_cnt = 0; fs_cnt = 0;
        disp_cnt = 0; disp_bad = -1;
        for (int k = 0; k < 127; k++) begin
            if (b_hs == 1'b1) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = int'(b_x);
                if (b_y == 3'd0) last_lo = int'(b_x);
            end
            if (b_vs == 1'b1) begin
                disp_cnt++;
                if (disp_bad < 0) disp_bad = int'(b_y);
            end
            if (b_fs) fs_cnt++;
            step();
        end
        check("b_hs_hi_cnt", lo_cnt, 24);
        check("b_hs_first_x", first_lo, 10);
        check("b_hs_last_x", last_lo, 12);
        check("b_vs_hi_cnt", disp_cnt, 32);
        check("b_vs_first_y", disp_bad, 5);
        check("b_fs_cnt", fs_cnt, 1);
        check("b_end_x", b_x, 15);
        check("b_end_y", b_y, 7);
        step();
        check("b_wrap_x", b_x, 0);
        check("b_wrap_y", b_y, 0);
        check("b_wrap_ls", b_ls, 1);
        check("b_wrap_fs", b_fs, 1);

        // ---- C: full 666-line frame on short lines ----
        pen_c = 1'b1;
        step();
        rst_c = 1'b0;
        step();
        lo_cnt = 0; first_lo = -1; last_lo = -1; fs_cnt = 0;
        disp_cnt = 0; disp_bad = 0; addr_c = 16'd0;
        for (int k = 0; k < 10656; k++) begin
            if (c_vs == 1'b0) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = int'(c_y);
                last_lo = int'(c_y);
            end
            if (c_disp) begin
                disp_cnt++;
                if (c_y >= 10'd600) disp_bad++;
            end
            if (c_x == 4'd7 && c_y == 10'd599) addr_c = c_addr;
            if (c_fs) fs_cnt++;
            step();
        end
        check("c_vs_low_cnt", lo_cnt, 96);
        check("c_vs_first_y", first_lo, 637);
        check("c_vs_last_y", last_lo, 642);
        check("c_disp_cnt", disp_cnt, 4800);
        check("c_disp_blank", disp_bad, 0);
        check("c_addr_y599", addr_c, 16'h9501);
        check("c_fs_cnt", fs_cnt, 1);
        check("c_frame_x", c_x, 0);
        check("c_frame_y", c_y, 0);
        check("c_frame_fs", c_fs, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 800x600@72 Hz timing block.
- Generates h/v sync, display-enable, pixel coordinates, a scaled framebuffer address, and line/frame start strobes.
- Fully single-clock: the vertical counter advances on an enable from the horizontal counter, not on a derived clock.
- Pixel-clock enable input allows sub-rate pixel clocks from one system clock.
- Sits between the system clock and the framebuffer read/colour output path.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels); H_TOTAL = sum = 1040
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum = 666
H_POL, 0, hsync active level (0 = active low)
V_POL, 0, vsync active level (0 = active low)
ADDR_SHIFT, 2, log2 of pixel replication factor for the address
ADDR_W_X, 8, x field width of pixel_addr_o
ADDR_W_Y, 8, y field width of pixel_addr_o

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel-clock enable; counters and outputs advance only when high
h_sync_o  out  1  horizontal sync, polarity per H_POL
v_sync_o  out  1  vertical sync, polarity per V_POL
in_disp_o  out  1  high when the current pixel is in the active area
x_o  out  clog2(H_TOTAL)  horizontal count of the current pixel
y_o  out  clog2(V_TOTAL)  vertical count of the current pixel
pixel_addr_o  out  ADDR_W_Y+ADDR_W_X  {y>>ADDR_SHIFT, x>>ADDR_SHIFT}, each field truncated to its width
line_start_o  out  1  one-clk strobe when outputs first show x=0
frame_start_o  out  1  one-clk strobe when outputs first show x=0, y=0

Behaviour:
- Internal counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1.
- On a clk edge with pix_en=1:
  - Output registers load the decode of the current (h_cnt, v_cnt).
  - h_cnt then increments and wraps to 0 after H_TOTAL-1.
  - v_cnt increments only on the h wrap, and wraps to 0 after V_TOTAL-1.
- Latency: outputs lag the counters by exactly one pix_en update. All outputs are mutually aligned: x_o/y_o, syncs, in_disp_o and pixel_addr_o describe the same pixel.
- pix_en=0: counters and all level outputs hold; both strobes clear to 0.
- Decode of pixel (h, v):
  - in_disp = h<H_ACTIVE && v<V_ACTIVE.
  - h sync window: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Same form for v with the V_ parameters.
  - Sync output = H_POL (or V_POL) inside its window, its inverse outside.
- pixel_addr_o tracks the current pixel only while in_disp; it is forced to 0 when in_disp=0.
- Strobe width: line_start_o/frame_start_o are high for exactly one clk, even when pix_en is held high continuously. Any clk without a new h=0 update clears them.
- Reset (rst=1, sampled at clk, overrides pix_en):
  - h_cnt=0, v_cnt=0.
  - Outputs: x_o=0, y_o=0, in_disp_o=0, pixel_addr_o=0, strobes=0, h_sync_o=~H_POL, v_sync_o=~V_POL.
  - First pix_en update after reset produces pixel (0,0) with line_start_o=frame_start_o=1.
- Reset mid-frame: same as above. No partial sync pulse persists beyond the reset cycle.
- Simultaneous wrap: at h=H_TOTAL-1 with v=V_TOTAL-1, both counters return to 0 on the same update.
- Elaboration: H_TOTAL>=2, V_TOTAL>=2, and all porch/sync parameters >=1. Otherwise stop the build with $error.

Decomposition:
- Shared package vga_timing_pkg holds:
  - Mode constant sets: 800x600@72 (50 MHz, pix_en=1) and 640x480@60 (25 MHz, pix_en every 2nd clk of 50 MHz).
  - A width helper function.
- One sub-module, vga_axis_counter, instantiated once per axis:
  - Parameters: ACTIVE, FP, SYNC, BP, POL.
  - Ports: clk, rst, adv, count, wrap, sync, active.
  - Horizontal instance: adv = pix_en. Vertical instance: adv = pix_en && h wrap.

Test Plan:
- Defaults, pix_en=1, release rst:
  - First update gives x=0, y=0, in_disp=1, frame_start=1 for one clk.
  - h_sync low for exactly 120 clks starting at x=856.
  - Line period is 1040 clks; frame period is 692640 clks.
- v_sync check: low for exactly 6 lines (6*1040 clks) beginning at y=637; in_disp=0 for all of y=600..665.
- pix_en toggling 1,0,1,0:
  - x_o advances every 2 clks.
  - line_start high 1 clk only.
  - Outputs hold during pix_en=0.
- Address check at x=799, y=599: pixel_addr_o = {8'd149, 8'd199}; at x=800 it is 0 and in_disp=0.
- Reset mid-frame at x=500, y=300: next clk all outputs at reset values; first pix_en gives (0,0) with both strobes high.
- Small mode H=8/2/3/3, V=4/1/2/1, H_POL=V_POL=1:
  - h_sync high for x=10..12.
  - Simultaneous wrap at (15,7) returns to (0,0) with frame_start.
